// File: rtl/sha3_block_padder.sv
// Packs a 64-bit word stream into 576-bit rate blocks with multi-rate
// padding, and holds each block until the permutation acknowledges it.
module sha3_block_padder #(
  parameter logic [7:0] PAD_FIRST = 8'h06,
  parameter logic [7:0] PAD_LAST  = 8'h80
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [63:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [2:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready,
  output logic         last_block,
  input  logic         f_ack
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    FULL   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     count_q, count_d;
  logic [575:0]   out_q, out_d;
  logic           last_q, last_d;

  logic           accept;
  logic           shift;
  logic           completes;
  logic [63:0]    keep_mask;
  logic [63:0]    pad_word;
  logic [63:0]    tail_word;
  logic [63:0]    w;

  // Tail word: keep bytes 0..k-1, PAD_FIRST at byte k, zeros after.
  assign keep_mask = ~({64{1'b1}} >> {byte_num, 3'b000});
  assign pad_word  = {PAD_FIRST, 56'd0} >> {byte_num, 3'b000};
  assign tail_word = (in & keep_mask) | pad_word;
  assign completes = (count_q == 4'd8);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (completes) begin
            state_d = FULL;
          end else if (is_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (completes) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (f_ack) begin
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    out_ready   = (count_q == 4'd9);
    buffer_full = (state_q != ACCEPT) | out_ready;
    accept      = in_ready & ~buffer_full;
    shift       = 1'b0;
    w           = '0;
    count_d     = count_q;
    out_d       = out_q;
    last_d      = last_q;
    unique case (state_q)
      ACCEPT: begin
        if (accept) begin
          shift = 1'b1;
          if (is_last) begin
            w      = tail_word;
            last_d = 1'b1;
            if (completes) begin
              w[7:0] = tail_word[7:0] | PAD_LAST;
            end
          end else begin
            w = in;
          end
        end
      end
      PAD: begin
        shift = 1'b1;
        if (completes) begin
          w[7:0] = PAD_LAST;
        end
      end
      FULL: begin
        if (f_ack) begin
          count_d = 4'd0;
          last_d  = 1'b0;
        end
      end
      default: begin
        count_d = 4'd0;
        last_d  = 1'b0;
      end
    endcase
    // Block content is never cleared; new words shift the old ones out.
    if (shift) begin
      out_d   = {out_q[511:0], w};
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 4'd0;
      out_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  assign out        = out_q;
  assign last_block = last_q;

endmodule

// File: tb/tb_sha3_block_padder.sv
// Scoreboard bench for sha3_block_padder: byte-level padding model,
// randomized messages, random f_ack back-pressure.
module tb_sha3_block_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [63:0]  in_w;
  logic         in_ready;
  logic         is_last;
  logic [2:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         last_block;
  logic         f_ack;

  int total = 0;
  int bad   = 0;

  logic [575:0] exp_out_q[$];
  logic         exp_last_q[$];
  logic [7:0]   cur_msg[$];

  bit           mon_en = 1'b0;
  bit           seen   = 1'b0;
  logic [575:0] held_out;
  logic         held_last;

  always #5 clk = ~clk;

  sha3_block_padder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .last_block  (last_block),
    .f_ack       (f_ack)
  );

  task automatic chk(input string name, input logic [575:0] act,
                     input logic [575:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: msg || PAD_FIRST || zeros to a 72-byte multiple,
  // PAD_LAST ORed into the final byte, split into 72-byte blocks.
  task automatic push_exp();
    logic [7:0]   p[$];
    logic [575:0] blk;
    int           nb;
    p = cur_msg;
    p.push_back(8'h06);
    while (p.size() % 72 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nb = p.size() / 72;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 72; j++) blk[575-8*j -: 8] = p[72*b+j];
      exp_out_q.push_back(blk);
      exp_last_q.push_back(b == nb - 1);
    end
  endtask

  // Monitor: pop on each new block, recheck while held, random f_ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_ready) begin
        if (!seen) begin
          if (exp_out_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got out_ready=1 want 0");
            held_out  = '0;
            held_last = 1'b0;
          end else begin
            held_out  = exp_out_q.pop_front();
            held_last = exp_last_q.pop_front();
          end
          seen = 1'b1;
        end
        chk("block_out", out, held_out);
        chk("block_last", {575'd0, last_block}, {575'd0, held_last});
        chk("full_stall", {575'd0, buffer_full}, 576'd1);
      end
      f_ack = ($urandom_range(0, 2) == 0);
      if (f_ack && out_ready) seen = 1'b0;
    end else begin
      f_ack = 1'b0;
    end
  end

  task automatic send_word(input logic [63:0] w, input bit last,
                           input logic [2:0] k);
    bit acc;
    int n;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_w     = w;
    is_last  = last;
    byte_num = k;
    in_ready = 1'b1;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = !buffer_full;
      @(posedge clk);
      #1;
      n++;
    end
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'($urandom);
    in_w     = {$urandom, $urandom};
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got buffer_full=1 want accept");
    end
  endtask

  task automatic send_msg(input bit push, input logic [63:0] fill,
                          input int lat);
    int          len;
    int          nf;
    int          k;
    logic [63:0] w;
    len = cur_msg.size();
    nf  = len / 8;
    k   = len % 8;
    if (push) push_exp();
    for (int i = 0; i < nf; i++) begin
      for (int j = 0; j < 8; j++) w[63-8*j -: 8] = cur_msg[8*i+j];
      send_word(w, 1'b0, 3'd0);
    end
    w = fill;
    for (int j = 0; j < k; j++) w[63-8*j -: 8] = cur_msg[8*nf+j];
    send_word(w, 1'b1, 3'(k));
    if (lat > 0) begin
      for (int n = 1; n <= lat; n++) begin
        @(negedge clk);
        chk($sformatf("latency_edge%0d", n), {575'd0, out_ready},
            {575'd0, (n == lat)});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_out_q.size() != 0 || buffer_full) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d blocks pending want 0",
               exp_out_q.size());
    end
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) cur_msg.push_back(8'($urandom));
  endtask

  initial begin
    reset_n  = 1'b0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'd0;
    in_w     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_ready", {575'd0, out_ready}, 576'd0);
    chk("rst_last_block", {575'd0, last_block}, 576'd0);
    chk("rst_buffer_full", {575'd0, buffer_full}, 576'd0);
    chk("rst_out", out, 576'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset while padding a short message discards it.
    cur_msg.delete();
    rand_bytes(16);
    send_msg(1'b0, 64'd0, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pad_busy", {575'd0, buffer_full}, 576'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_ready", {575'd0, out_ready}, 576'd0);
    chk("midrst_last_block", {575'd0, last_block}, 576'd0);
    chk("midrst_buffer_full", {575'd0, buffer_full}, 576'd0);
    chk("midrst_out", out, 576'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Empty message: pad-only block after 9 edges.
    cur_msg.delete();
    send_msg(1'b1, 64'hDEADBEEFCAFEF00D, 9);
    wait_drain();

    // 71 bytes: last byte carries PAD_FIRST|PAD_LAST.
    cur_msg.delete();
    rand_bytes(64);
    cur_msg.push_back(8'hAA);
    cur_msg.push_back(8'hBB);
    cur_msg.push_back(8'hCC);
    cur_msg.push_back(8'hDD);
    cur_msg.push_back(8'hEE);
    cur_msg.push_back(8'hFF);
    cur_msg.push_back(8'h11);
    send_msg(1'b1, 64'h0123456789ABCD22, 1);
    wait_drain();

    // 67 bytes: 3-byte tail, pad then PAD_LAST in the same word.
    cur_msg.delete();
    rand_bytes(64);
    cur_msg.push_back(8'h11);
    cur_msg.push_back(8'h22);
    cur_msg.push_back(8'h33);
    send_msg(1'b1, {$urandom, $urandom}, 1);
    wait_drain();

    // Words 0..8 then a second full block, then an empty last word.
    cur_msg.delete();
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 7; j++) cur_msg.push_back(8'h00);
      cur_msg.push_back(8'(i));
    end
    rand_bytes(72);
    send_msg(1'b1, {$urandom, $urandom}, 9);
    wait_drain();

    // Random back-to-back messages.
    for (int m = 0; m < 40; m++) begin
      cur_msg.delete();
      rand_bytes($urandom_range(0, 220));
      send_msg(1'b1, {$urandom, $urandom}, 0);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
